seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 199 +++++++++++++++++++
 tb/tb_seq_alu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: base ops complete in one cycle; M ops run a 1-bit/cycle shift-add
// multiplier or restoring divider on operand magnitudes, with the sign fixed up at the end.
module seq_alu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dataa,
  input  logic [XLEN-1:0] datab,
  input  logic [2:0]      ALUctr,
  input  logic            ALUext,
  input  logic            mdu_en,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluresult,
  output logic            less,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  hi_q, lo_q, b_q;
  logic [2:0]       op_q;
  logic             neg_q;

  assign in_ready = (state_q == StIdle);

  // ---------------- single-cycle base ops ----------------
  logic [XLEN:0]   sub_w;
  logic            ovf_w, slt_w, sltu_w;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sra_w, base_res;
  logic            base_less, base_zero;

  assign sub_w  = {1'b0, dataa} - {1'b0, datab};
  assign ovf_w  = (dataa[XLEN-1] ^ datab[XLEN-1]) & (sub_w[XLEN-1] ^ dataa[XLEN-1]);
  assign slt_w  = sub_w[XLEN-1] ^ ovf_w;
  assign sltu_w = sub_w[XLEN];
  assign shamt  = datab[SHW-1:0];
  // Kept separate so the arithmetic shift is not forced unsigned by a mixed ternary.
  assign sra_w  = $signed(dataa) >>> shamt;

  always_comb begin
    base_res  = '0;
    base_less = 1'b0;
    case (ALUctr)
      3'd0: base_res = ALUext ? sub_w[XLEN-1:0] : dataa + datab;
      3'd1: base_res = dataa << shamt;
      3'd2: begin
        base_less = slt_w;
        base_res  = {{(XLEN-1){1'b0}}, slt_w};
      end
      3'd3: begin
        base_less = sltu_w;
        base_res  = {{(XLEN-1){1'b0}}, sltu_w};
      end
      3'd4: base_res = dataa ^ datab;
      3'd5: base_res = ALUext ? sra_w : dataa >> shamt;
      3'd6: base_res = dataa | datab;
      default: base_res = dataa & datab;
    endcase
  end

  assign base_zero = (ALUctr == 3'd2 || ALUctr == 3'd3) ? (dataa == datab)
                                                       : (base_res == '0);

  // ---------------- M-op setup ----------------
  logic            a_sgn, b_sgn, start_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn = dataa[XLEN-1] &
                 (ALUctr == 3'd1 || ALUctr == 3'd2 || ALUctr == 3'd4 || ALUctr == 3'd6);
  assign b_sgn = datab[XLEN-1] & (ALUctr == 3'd1 || ALUctr == 3'd4 || ALUctr == 3'd6);
  assign a_mag = a_sgn ? -dataa : dataa;
  assign b_mag = b_sgn ? -datab : datab;

  // Divide-by-zero must leave the all-ones quotient unnegated.
  always_comb begin
    if (!ALUctr[2])      start_neg = a_sgn ^ b_sgn;
    else if (!ALUctr[1]) start_neg = (a_sgn ^ b_sgn) & (datab != '0);
    else                 start_neg = a_sgn;
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [XLEN-1:0]   hi_n, lo_n, quo_s, rem_s, mdu_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, b_q};

  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    if (op_q[2]) begin
      if (div_diff[XLEN]) begin
        hi_n = div_sh[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end else begin
        hi_n = div_diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_n : lo_n;
  assign rem_s  = neg_q ? -hi_n : hi_n;

  always_comb begin
    mdu_res = rem_s;
    case (op_q)
      3'd0:                mdu_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    mdu_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          mdu_res = quo_s;
      default:             mdu_res = rem_s;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      aluresult <= '0;
      less      <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && !kill) begin
            if (mdu_en) begin
              state_q <= StBusy;
              cnt_q   <= CNT_W'(XLEN);
              hi_q    <= '0;
              lo_q    <= a_mag;
              b_q     <= b_mag;
              op_q    <= ALUctr;
              neg_q   <= start_neg;
            end else begin
              state_q   <= StDone;
              aluresult <= base_res;
              less      <= base_less;
              zero      <= base_zero;
              out_valid <= 1'b1;
            end
          end
        end
        StBusy: begin
          if (kill) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q   <= StDone;
              aluresult <= mdu_res;
              less      <= 1'b0;
              zero      <= (mdu_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        StDone: begin
          if (kill || out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at XLEN=32.
module tb_seq_alu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dataa;
  logic [XLEN-1:0] datab;
  logic [2:0]      ALUctr;
  logic            ALUext;
  logic            mdu_en;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] aluresult;
  logic            less;
  logic            zero;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataa     (dataa),
    .datab     (datab),
    .ALUctr    (ALUctr),
    .ALUext    (ALUext),
    .mdu_en    (mdu_en),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluresult (aluresult),
    .less      (less),
    .zero      (zero)
  );

  typedef struct {
    string       name;
    logic        md;
    logic [2:0]  op;
    logic        ext;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ls;
    logic        zr;
    int          lat;
  } vec_t;

  function automatic vec_t mk(string nm, logic md, logic [2:0] op, logic ext,
                              logic [31:0] a, logic [31:0] b, logic [31:0] r,
                              logic ls, logic zr);
    vec_t v;
    v.name = nm; v.md = md; v.op = op; v.ext = ext; v.a = a; v.b = b;
    v.res = r; v.ls = ls; v.zr = zr;
    v.lat = md ? XLEN + 1 : 1;
    return v;
  endfunction

  task automatic start_op(input logic md, input logic [2:0] op, input logic ext,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; mdu_en = md; ALUctr = op; ALUext = ext; dataa = a; datab = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat counts edges from the accepting edge (1) until out_valid is seen.
  task automatic wait_valid(input int budget, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat <= budget) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t v, output int lat, output logic [31:0] res,
                        output logic ls, output logic zr);
    start_op(v.md, v.op, v.ext, v.a, v.b);
    wait_valid(XLEN + 5, lat);
    res = aluresult; ls = less; zr = zero;
    consume();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (aluresult !== 32'h0) $display("FAIL reset_aluresult got %h want 0", aluresult); else n_pass++;
    n_total++; if ({less, zero} !== 2'b00) $display("FAIL reset_flags got %b want 00", {less, zero}); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_base;
    vec_t q[$];
    int lat; logic [31:0] res; logic ls, zr;
    q.push_back(mk("add_ovf",  0, 3'd0, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0));
    q.push_back(mk("sub_zero", 0, 3'd0, 1, 32'h5,        32'h5,        32'h0,        0, 1));
    q.push_back(mk("add_wrap", 0, 3'd0, 0, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1));
    q.push_back(mk("sll_mask", 0, 3'd1, 0, 32'h1,        32'h24,       32'h10,       0, 0));
    q.push_back(mk("slt_neg",  0, 3'd2, 0, 32'h80000000, 32'h1,        32'h1,        1, 0));
    q.push_back(mk("sltu_big", 0, 3'd3, 0, 32'h80000000, 32'h1,        32'h0,        0, 0));
    q.push_back(mk("slt_eq",   0, 3'd2, 0, 32'h5,        32'h5,        32'h0,        0, 1));
    q.push_back(mk("slt_ovf",  0, 3'd2, 0, 32'h7FFFFFFF, 32'h80000000, 32'h0,        0, 0));
    q.push_back(mk("sltu_ovf", 0, 3'd3, 0, 32'h7FFFFFFF, 32'h80000000, 32'h1,        1, 0));
    q.push_back(mk("xor",      0, 3'd4, 0, 32'hF0F01234, 32'h0FF0FFFF, 32'hFF00EDCB, 0, 0));
    q.push_back(mk("sra",      0, 3'd5, 1, 32'h80000000, 32'h4,        32'hF8000000, 0, 0));
    q.push_back(mk("srl",      0, 3'd5, 0, 32'h80000000, 32'h4,        32'h08000000, 0, 0));
    q.push_back(mk("sra_mask", 0, 3'd5, 1, 32'hC0000001, 32'h21,       32'hE0000000, 0, 0));
    q.push_back(mk("or",       0, 3'd6, 0, 32'hF0F01234, 32'h0FF0FFFF, 32'hFFF0FFFF, 0, 0));
    q.push_back(mk("and",      0, 3'd7, 0, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 0, 0));
    foreach (q[i]) begin
      run_op(q[i], lat, res, ls, zr);
      n_total++; if (lat !== q[i].lat) $display("FAIL %s latency got %0d want %0d", q[i].name, lat, q[i].lat); else n_pass++;
      n_total++; if (res !== q[i].res) $display("FAIL %s aluresult got %h want %h", q[i].name, res, q[i].res); else n_pass++;
      n_total++; if ({ls, zr} !== {q[i].ls, q[i].zr}) $display("FAIL %s less/zero got %b%b want %b%b", q[i].name, ls, zr, q[i].ls, q[i].zr); else n_pass++;
    end
  endtask

  task automatic test_mdu;
    vec_t q[$];
    int lat; logic [31:0] res; logic ls, zr;
    q.push_back(mk("mulh_m1",    1, 3'd1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 1));
    q.push_back(mk("mulhu_max",  1, 3'd3, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0));
    q.push_back(mk("mul_neg",    1, 3'd0, 0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0));
    q.push_back(mk("mul_shift",  1, 3'd0, 0, 32'h12345678, 32'h10,       32'h23456780, 0, 0));
    q.push_back(mk("mulhsu",     1, 3'd2, 0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, 0));
    q.push_back(mk("mulh_min",   1, 3'd1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0));
    q.push_back(mk("div_ovf",    1, 3'd4, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0));
    q.push_back(mk("rem_ovf",    1, 3'd6, 0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 1));
    q.push_back(mk("divu_zero",  1, 3'd5, 0, 32'h7,        32'h0,        32'hFFFFFFFF, 0, 0));
    q.push_back(mk("remu_zero",  1, 3'd7, 0, 32'h7,        32'h0,        32'h7,        0, 0));
    q.push_back(mk("div_negz",   1, 3'd4, 0, 32'hFFFFFFF8, 32'h0,        32'hFFFFFFFF, 0, 0));
    q.push_back(mk("rem_negz",   1, 3'd6, 0, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 0, 0));
    q.push_back(mk("rem_neg",    1, 3'd6, 0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, 0));
    q.push_back(mk("div_neg",    1, 3'd4, 0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, 0));
    q.push_back(mk("divu",       1, 3'd5, 0, 32'd100,      32'd7,        32'd14,       0, 0));
    q.push_back(mk("remu",       1, 3'd7, 0, 32'd100,      32'd7,        32'd2,        0, 0));
    foreach (q[i]) begin
      run_op(q[i], lat, res, ls, zr);
      n_total++; if (lat !== q[i].lat) $display("FAIL %s latency got %0d want %0d", q[i].name, lat, q[i].lat); else n_pass++;
      n_total++; if (res !== q[i].res) $display("FAIL %s aluresult got %h want %h", q[i].name, res, q[i].res); else n_pass++;
      n_total++; if ({ls, zr} !== {q[i].ls, q[i].zr}) $display("FAIL %s less/zero got %b%b want %b%b", q[i].name, ls, zr, q[i].ls, q[i].zr); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(1'b0, 3'd0, 1'b0, 32'd3, 32'd4);
    wait_valid(5, lat);
    for (int k = 0; k < 5; k++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (aluresult !== 32'd7) $display("FAIL hold_result[%0d] got %h want 7", k, aluresult); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d] got %b want 0", k, in_ready); else n_pass++;
      @(posedge clk); #1;
    end
    // Release while a new request is already waiting: it must not be taken this edge.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; mdu_en = 1'b0; ALUctr = 3'd0; ALUext = 1'b0; dataa = 32'd10; datab = 32'd20;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL release_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL next_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (aluresult !== 32'd30) $display("FAIL next_result got %h want 1e", aluresult); else n_pass++;
    consume();
  endtask

  task automatic test_kill_reset;
    int lat;
    logic seen;
    start_op(1'b1, 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL kill_busy_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL kill_busy_in_ready got %b want 1", in_ready); else n_pass++;

    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; mdu_en = 1'b0; ALUctr = 3'd0; dataa = 32'd1; datab = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL kill_idle_in_ready got %b want 1", in_ready); else n_pass++;
    seen = out_valid;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL kill_quiet out_valid seen %b want 0", seen); else n_pass++;

    start_op(1'b0, 3'd0, 1'b0, 32'd1, 32'd2);
    wait_valid(5, lat);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL kill_done_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL kill_done_in_ready got %b want 1", in_ready); else n_pass++;

    // Reset mid-BUSY with a competing request and kill asserted.
    start_op(1'b1, 3'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_busy_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (aluresult !== 32'h0) $display("FAIL rst_busy_result got %h want 0", aluresult); else n_pass++;
    n_total++; if ({less, zero} !== 2'b00) $display("FAIL rst_busy_flags got %b want 00", {less, zero}); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_busy_in_ready got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; kill = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rst_quiet out_valid seen %b want 0", seen); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; dataa = '0; datab = '0; ALUctr = '0; ALUext = 1'b0;
    mdu_en = 1'b0; kill = 1'b0; out_ready = 1'b0;
    test_reset();
    test_base();
    test_mdu();
    test_back_to_back();
    test_kill_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
